asynch: RTL and testbench



---
 rtl/asynch_pkg.sv | 10 +
 rtl/asynch_tff.sv | 25 ++
 rtl/asynch.sv | 75 +++++++
 tb/tb_asynch.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/asynch_pkg.sv
// rtl/asynch_pkg.sv - shared constants for the asynch 4-stage toggle counter
package asynch_pkg;

    // Number of toggle stages (Q0..Q3).
    localparam int ASYNCH_STAGES = 4;

    // Value loaded into the stage vector (and edge-history flops) on reset.
    localparam logic [ASYNCH_STAGES-1:0] ASYNCH_RST_VAL = 4'b0000;

endpackage

// File: rtl/asynch_tff.sv
// rtl/asynch_tff.sv - single toggle flop with synchronous active-low clear
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-low clear (loads RST_VAL)
//   tgl_en  invert q on the rising edge when 1
//   q       registered stage output
module asynch_tff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tgl_en,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (tgl_en) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/asynch.sv
// rtl/asynch.sv - 4-bit binary up counter with ripple-emulation option (ASYNCH_RIPPLE_EN)
//
// Ports:
//   clk     sole clock, all state updates on the rising edge
//   rst     synchronous active-low reset; clears every stage and history flop
//   Q0..Q3  registered count bits, Q0 is the LSB
//
// Build option:
//   ASYNCH_RIPPLE_EN undefined : synchronous count, stage n toggles when all
//                                lower stages are 1 (no inter-stage delay).
//   ASYNCH_RIPPLE_EN defined   : stage n toggles one clock after stage n-1
//                                falls, detected against a registered copy.
module asynch
    import asynch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3
);

    logic [ASYNCH_STAGES-1:0] stage;
    logic [ASYNCH_STAGES-1:0] tgl_en;

`ifdef ASYNCH_RIPPLE_EN
    // Previous-cycle copy of each stage that feeds a higher stage. A 1->0
    // transition shows up as hist=1 while the live stage is 0, for exactly
    // one cycle, so the next stage toggles on the edge after the fall.
    logic [ASYNCH_STAGES-2:0] hist;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist <= ASYNCH_RST_VAL[ASYNCH_STAGES-2:0];
        end else begin
            hist <= stage[ASYNCH_STAGES-2:0];
        end
    end

    always_comb begin
        tgl_en    = '0;
        tgl_en[0] = 1'b1;
        for (int i = 1; i < ASYNCH_STAGES; i++) begin
            tgl_en[i] = hist[i-1] & ~stage[i-1];
        end
    end
`else
    // Carry chain: stage n toggles when every lower stage is 1.
    always_comb begin
        tgl_en    = '0;
        tgl_en[0] = 1'b1;
        for (int i = 1; i < ASYNCH_STAGES; i++) begin
            tgl_en[i] = tgl_en[i-1] & stage[i-1];
        end
    end
`endif

    for (genvar g = 0; g < ASYNCH_STAGES; g++) begin : g_stage
        asynch_tff #(
            .RST_VAL (ASYNCH_RST_VAL[g])
        ) u_tff (
            .clk     (clk),
            .rst     (rst),
            .tgl_en  (tgl_en[g]),
            .q       (stage[g])
        );
    end

    assign Q0 = stage[0];
    assign Q1 = stage[1];
    assign Q2 = stage[2];
    assign Q3 = stage[3];

endmodule

// File: tb/tb_asynch.sv
// tb/tb_asynch.sv - self-checking bench for asynch (model + directed literals)
module tb_asynch;

    logic clk;
    logic rst;
    logic Q0, Q1, Q2, Q3;

    int checks = 0;
    int passes = 0;

    // Model state: number of counting edges since the last reset edge.
    int  t_cnt     = 0;
    bit  model_ok  = 1'b0;

    asynch dut (
        .clk (clk),
        .rst (rst),
        .Q0  (Q0),
        .Q1  (Q1),
        .Q2  (Q2),
        .Q3  (Q3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output after t counting edges, straight from the counting rule.
    function automatic logic [3:0] expect_of(input int t);
        logic [3:0] e;
`ifdef ASYNCH_RIPPLE_EN
        for (int n = 0; n < 4; n++) begin
            int v;
            v = (t > n) ? (t - n) : 0;
            e[n] = ((v >> n) & 1) != 0;
        end
`else
        e = 4'(t % 16);
`endif
        return e;
    endfunction

    function automatic logic [3:0] outs();
        return {Q3, Q2, Q1, Q0};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %b expected %b (t=%0d)", name, act, exp, t_cnt);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model update follows the rst value sampled at each rising edge.
    always @(posedge clk) begin
        if (!rst) begin
            t_cnt    <= 0;
            model_ok <= 1'b1;
        end else begin
            t_cnt <= t_cnt + 1;
        end
    end

    // Every-cycle comparison once the model has a defined starting point.
    always @(negedge clk) begin
        if (model_ok) begin
            check("model", outs(), expect_of(t_cnt));
        end
    end

    // Drive rst for the next rising edge, then return at the following
    // falling edge where outputs are stable.
    task automatic edge_with(input logic v);
        rst = v;
        @(posedge clk);
        @(negedge clk);
    endtask

`ifdef ASYNCH_RIPPLE_EN
    logic [3:0] ripple_tbl [11] = '{4'b0001, 4'b0000, 4'b0011, 4'b0010,
                                   4'b0001, 4'b0100, 4'b0111, 4'b0110,
                                   4'b0101, 4'b0000, 4'b1011};
`endif

    logic [3:0] hist64 [64];

    initial begin
        rst = 1'b1;
        @(negedge clk);
        // Free-run from arbitrary power-up state.
        edge_with(1'b1);
        edge_with(1'b1);
        edge_with(1'b1);

        // Reset held for two edges.
        edge_with(1'b0);
        check("reset_edge1", outs(), 4'b0000);
        edge_with(1'b0);
        check("reset_edge2", outs(), 4'b0000);

        // Count sequence after release.
`ifdef ASYNCH_RIPPLE_EN
        for (int i = 0; i < 11; i++) begin
            edge_with(1'b1);
            check($sformatf("ripple_seq%0d", i + 1), outs(), ripple_tbl[i]);
        end
`else
        for (int i = 1; i <= 16; i++) begin
            edge_with(1'b1);
            if (i == 1)  check("count_first", outs(), 4'b0001);
            if (i == 7)  check("count_7", outs(), 4'b0111);
            if (i == 15) check("count_max", outs(), 4'b1111);
            if (i == 16) check("count_wrap", outs(), 4'b0000);
        end

        // Frequency division over 64 edges starting from a clean count.
        edge_with(1'b0);
        for (int i = 0; i < 64; i++) begin
            edge_with(1'b1);
            hist64[i] = outs();
        end
        for (int n = 0; n < 4; n++) begin
            int rises;
            int highs;
            int first_r;
            int last_r;
            rises = 0; highs = 0; first_r = -1; last_r = -1;
            for (int i = 0; i < 64; i++) begin
                if (hist64[i][n]) highs++;
                if (i > 0 && hist64[i][n] && !hist64[i-1][n]) begin
                    rises++;
                    if (first_r < 0) first_r = i;
                    last_r = i;
                end
            end
            check_int($sformatf("duty_q%0d", n), highs, 32);
            check_int($sformatf("period_q%0d", n), last_r - first_r,
                      (rises - 1) * (2 << n));
            check_int($sformatf("rises_q%0d", n), rises, (n == 0) ? 31 : 64 / (2 << n));
        end
`endif

        // Mid-count reset at 0111.
        edge_with(1'b0);
        for (int i = 0; i < 7; i++) edge_with(1'b1);
        check("mid_pre", outs(), 4'b0111);
        edge_with(1'b0);
        check("mid_reset", outs(), 4'b0000);
        edge_with(1'b1);
        check("mid_release", outs(), 4'b0001);
        for (int i = 0; i < 6; i++) edge_with(1'b1);

        // Short one-edge reset pulse followed by counting.
        edge_with(1'b0);
        check("pulse_clear", outs(), 4'b0000);
        edge_with(1'b1);
        check("pulse_first", outs(), 4'b0001);
        edge_with(1'b1);
`ifdef ASYNCH_RIPPLE_EN
        check("pulse_second", outs(), 4'b0000);
`else
        check("pulse_second", outs(), 4'b0010);
`endif
        edge_with(1'b1);
        check("pulse_third", outs(), 4'b0011);

        // Back-to-back release/assert.
        edge_with(1'b0);
        edge_with(1'b1);
        edge_with(1'b0);
        check("toggle_rst", outs(), 4'b0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
